// File: rtl/systolic_skew_feeder_pkg.sv
// Shared definitions for the systolic array feeder and the downstream collector.
package systolic_pkg;

  localparam int unsigned DefDataW = 8;
  localparam int unsigned DefN     = 4;
  localparam int unsigned DefK     = 4;

  typedef enum logic [2:0] {
    StIdle,
    StClear,
    StStream,
    StDrain,
    StDone
  } feeder_state_t;

endpackage

// File: rtl/systolic_skew_feeder_if.sv
// Beat handshake plus array-edge drive bundle for the skew feeder.
interface systolic_skew_feeder_if
  import systolic_pkg::*;
#(
  parameter int unsigned DATA_W = DefDataW,
  parameter int unsigned N      = DefN
);

  logic                start;
  logic                in_valid;
  logic                in_ready;
  logic [N*DATA_W-1:0] in_a_vec;
  logic [N*DATA_W-1:0] in_b_vec;
  logic [N*DATA_W-1:0] array_a;
  logic [N*DATA_W-1:0] array_b;
  logic                array_clr;
  logic                busy;
  logic                done;

  modport master (
    output start, in_valid, in_a_vec, in_b_vec,
    input  in_ready, array_a, array_b, array_clr, busy, done
  );

  modport slave (
    input  start, in_valid, in_a_vec, in_b_vec,
    output in_ready, array_a, array_b, array_clr, busy, done
  );

endinterface

// File: rtl/systolic_skew_feeder_delay.sv
// Fixed-depth register chain used to skew one operand lane.
module skew_delay_line #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  logic [WIDTH-1:0] stage_q [DEPTH];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int s = 0; s < DEPTH; s++) stage_q[s] <= '0;
    end else begin
      stage_q[0] <= din;
      for (int s = 1; s < DEPTH; s++) stage_q[s] <= stage_q[s-1];
    end
  end

  assign dout = stage_q[DEPTH-1];

endmodule

// File: rtl/systolic_skew_feeder.sv
// Job sequencer and triangular operand skew for the west/north edges of an NxN PE array.
module systolic_skew_feeder
  import systolic_pkg::*;
#(
  parameter int unsigned DATA_W = DefDataW,
  parameter int unsigned N      = DefN,
  parameter int unsigned K      = DefK
) (
  input  logic                   clk,
  input  logic                   reset,
  systolic_skew_feeder_if.slave  bus
);

  localparam int unsigned BeatW  = $clog2(K + 1);
  localparam int unsigned DrainW = $clog2(2 * N);

  feeder_state_t     state_q, state_d;
  logic [BeatW-1:0]  beat_q, beat_d;
  logic [DrainW-1:0] drain_q, drain_d;
  logic              accept;

  assign accept = (state_q == StStream) && bus.in_valid;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
      beat_q  <= '0;
      drain_q <= '0;
    end else begin
      state_q <= state_d;
      beat_q  <= beat_d;
      drain_q <= drain_d;
    end
  end

  always_comb begin
    state_d = state_q;
    beat_d  = beat_q;
    drain_d = drain_q;
    unique case (state_q)
      StIdle:  if (bus.start) state_d = StClear;
      StClear: state_d = StStream;
      StStream: begin
        if (accept) begin
          if (beat_q == BeatW'(K - 1)) begin
            beat_d  = '0;
            state_d = StDrain;
          end else begin
            beat_d = beat_q + 1'b1;
          end
        end
      end
      // 2N-1 zero cycles flush the deepest lane through the far corner PE.
      StDrain: begin
        if (drain_q == DrainW'(2 * N - 2)) begin
          drain_d = '0;
          state_d = StDone;
        end else begin
          drain_d = drain_q + 1'b1;
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  assign bus.in_ready  = (state_q == StStream);
  assign bus.array_clr = (state_q == StClear);
  assign bus.busy      = (state_q != StIdle);
  assign bus.done      = (state_q == StDone);

  // Lane i is i+1 registers deep; non-accepted cycles shift in zeros.
  for (genvar i = 0; i < N; i++) begin : g_lane
    logic [DATA_W-1:0] a_in, b_in;
    assign a_in = accept ? bus.in_a_vec[i*DATA_W +: DATA_W] : '0;
    assign b_in = accept ? bus.in_b_vec[i*DATA_W +: DATA_W] : '0;

    skew_delay_line #(
      .WIDTH (DATA_W),
      .DEPTH (i + 1)
    ) u_skew_a (
      .clk   (clk),
      .reset (reset),
      .din   (a_in),
      .dout  (bus.array_a[i*DATA_W +: DATA_W])
    );

    skew_delay_line #(
      .WIDTH (DATA_W),
      .DEPTH (i + 1)
    ) u_skew_b (
      .clk   (clk),
      .reset (reset),
      .din   (b_in),
      .dout  (bus.array_b[i*DATA_W +: DATA_W])
    );
  end

endmodule

// File: tb/tb_systolic_skew_feeder.sv
// Bench: feeder driving a behavioural 4x4 PE array; scoreboard checks done timing and out_c.
module tb_systolic_skew_feeder;
  import systolic_pkg::*;

  localparam int unsigned DW = 8;
  localparam int unsigned N  = 4;
  localparam int unsigned K  = 4;

  typedef logic [N*N-1:0][DW-1:0] mat8_t;
  typedef logic [N*N-1:0][31:0]   mat32_t;

  typedef struct packed {
    logic [31:0] cyc;
    mat32_t      c;
  } exp_t;

  typedef struct packed {
    logic [31:0]       cyc;
    logic [N*DW-1:0]   v;
  } sk_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  systolic_skew_feeder_if #(.DATA_W(DW), .N(N)) bus ();

  systolic_skew_feeder #(.DATA_W(DW), .N(N), .K(K)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input longint unsigned act, input longint unsigned exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Behavioural output-stationary PE array fed from the DUT edges.
  logic [DW-1:0] pa [N][N];
  logic [DW-1:0] pb [N][N];
  logic [31:0]   pc [N][N];

  function automatic logic [DW-1:0] a_in_of(input int i, input int j);
    if (j == 0) return bus.array_a[i*DW +: DW];
    return pa[i][j-1];
  endfunction

  function automatic logic [DW-1:0] b_in_of(input int i, input int j);
    if (i == 0) return bus.array_b[j*DW +: DW];
    return pb[i-1][j];
  endfunction

  always @(posedge clk) begin
    for (int i = 0; i < N; i++) begin
      for (int j = 0; j < N; j++) begin
        if (reset || bus.array_clr) begin
          pa[i][j] <= '0;
          pb[i][j] <= '0;
          pc[i][j] <= '0;
        end else begin
          pa[i][j] <= a_in_of(i, j);
          pb[i][j] <= b_in_of(i, j);
          pc[i][j] <= pc[i][j] + 32'(a_in_of(i, j)) * 32'(b_in_of(i, j));
        end
      end
    end
  end

  exp_t sb_q[$];
  sk_t  sk_q[$];

  always @(negedge clk) begin : done_monitor
    exp_t e;
    if (!reset && bus.done) begin
      if (sb_q.size() == 0) begin
        check("unexpected_done", 1, 0);
      end else begin
        e = sb_q.pop_front();
        check("done_cycle", cyc, e.cyc);
        for (int i = 0; i < N; i++)
          for (int j = 0; j < N; j++)
            check($sformatf("out_c[%0d][%0d]", i, j), pc[i][j], e.c[i*N+j]);
      end
    end
  end

  always @(negedge clk) begin : skew_monitor
    sk_t s;
    if (sk_q.size() != 0 && sk_q[0].cyc == cyc) begin
      s = sk_q.pop_front();
      check("skew_array_a", bus.array_a, s.v);
      check("skew_array_b", bus.array_b, s.v);
    end
  end

  task automatic run_job(input mat8_t am, input mat8_t bm, input mat32_t cexp,
                         input int bub_at, input int bub_len, input bit glitch, input bit skew);
    exp_t e;
    sk_t  s;
    int   s_cyc;
    int   waited;
    @(posedge clk); #1;
    s_cyc = cyc;
    e.cyc = s_cyc + K + 2 * N + 1 + bub_len;
    e.c   = cexp;
    sb_q.push_back(e);
    if (skew) begin
      // First beat is accepted in cycle S+2; lane d shows it in S+3+d only.
      for (int d = -1; d <= int'(N); d++) begin
        s.cyc = s_cyc + 3 + d;
        s.v   = '0;
        if (d >= 0 && d < int'(N)) s.v[d*DW +: DW] = 8'hFF;
        sk_q.push_back(s);
      end
    end
    bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    check("clr_in_clear", bus.array_clr, 1);
    @(posedge clk); #1;
    for (int k = 0; k < int'(K); k++) begin
      if (k == bub_at) begin
        repeat (bub_len) begin
          bus.in_valid = 1'b0;
          bus.in_a_vec = 32'hA5A5_A5A5;
          bus.in_b_vec = 32'h5A5A_5A5A;
          @(posedge clk); #1;
        end
      end
      bus.in_valid = 1'b1;
      for (int i = 0; i < int'(N); i++) begin
        bus.in_a_vec[i*DW +: DW] = am[i*N+k];
        bus.in_b_vec[i*DW +: DW] = bm[k*N+i];
      end
      if (glitch && k == 1) bus.start = 1'b1;
      check("in_ready_beat", bus.in_ready, 1);
      @(posedge clk); #1;
      bus.start = 1'b0;
    end
    bus.in_valid = 1'b0;
    bus.in_a_vec = '0;
    bus.in_b_vec = '0;
    if (glitch) begin
      bus.start    = 1'b1;
      bus.in_valid = 1'b1;
      bus.in_a_vec = 32'hFFFF_FFFF;
      bus.in_b_vec = 32'hFFFF_FFFF;
      check("drain_not_ready", bus.in_ready, 0);
      @(posedge clk); #1;
      bus.start    = 1'b0;
      bus.in_valid = 1'b0;
      bus.in_a_vec = '0;
      bus.in_b_vec = '0;
    end
    waited = 0;
    while (sb_q.size() != 0 && waited < 100) begin
      @(posedge clk);
      waited++;
    end
    if (sb_q.size() != 0) begin
      check("done_timeout", 0, 1);
      sb_q.delete();
    end
    @(posedge clk); #1;
    check("idle_after_done_busy", bus.busy, 0);
  endtask

  mat8_t  a_id, b_id, b_rev, a_max, a_sk, b_sk;
  mat32_t c_id, c_rev, c_max, c_sk;

  initial begin
    bus.start    = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_a_vec = '0;
    bus.in_b_vec = '0;

    for (int i = 0; i < int'(N); i++) begin
      for (int j = 0; j < int'(N); j++) begin
        a_id[i*N+j]  = 8'(i * N + j + 1);
        b_id[i*N+j]  = (i == j) ? 8'd1 : 8'd0;
        b_rev[i*N+j] = (i + j == int'(N) - 1) ? 8'd1 : 8'd0;
        a_max[i*N+j] = 8'd255;
        a_sk[i*N+j]  = (j == 0) ? 8'hFF : 8'h00;
        b_sk[i*N+j]  = (i == 0) ? 8'hFF : 8'h00;
        c_id[i*N+j]  = 32'(i * N + j + 1);
        c_rev[i*N+j] = 32'(i * N + (int'(N) - 1 - j) + 1);
        c_max[i*N+j] = 32'd260100;
        c_sk[i*N+j]  = 32'd65025;
      end
    end

    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", bus.busy, 0);
    check("rst_in_ready", bus.in_ready, 0);
    check("rst_array_a", bus.array_a, 0);
    reset = 1'b0;

    // Reset mid-STREAM abandons the job with no done.
    @(posedge clk); #1;
    bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    @(posedge clk); #1;
    bus.in_valid = 1'b1;
    bus.in_a_vec = 32'h1111_1111;
    bus.in_b_vec = 32'h2222_2222;
    @(posedge clk); #1;
    check("stream_busy_before_reset", bus.busy, 1);
    #3 reset = 1'b1;
    #1;
    check("midrst_busy", bus.busy, 0);
    check("midrst_in_ready", bus.in_ready, 0);
    check("midrst_array_clr", bus.array_clr, 0);
    check("midrst_done", bus.done, 0);
    check("midrst_array_a", bus.array_a, 0);
    check("midrst_array_b", bus.array_b, 0);
    @(posedge clk); #1;
    reset = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_a_vec = '0;
    bus.in_b_vec = '0;

    run_job(a_id, b_id, c_id, -1, 0, 1'b0, 1'b0);
    run_job(a_sk, b_sk, c_sk, -1, 0, 1'b0, 1'b1);
    run_job(a_id, b_id, c_id, 1, 3, 1'b0, 1'b0);
    run_job(a_max, a_max, c_max, -1, 0, 1'b0, 1'b0);

    // in_valid held in IDLE (and through CLEAR) must not be taken as a beat.
    bus.in_valid = 1'b1;
    bus.in_a_vec = 32'h7777_7777;
    bus.in_b_vec = 32'h7777_7777;
    repeat (3) begin
      @(posedge clk); #1;
      check("idle_not_ready", bus.in_ready, 0);
      check("idle_not_busy", bus.busy, 0);
    end
    run_job(a_id, b_rev, c_rev, -1, 0, 1'b1, 1'b0);

    repeat (20) @(posedge clk);
    #1;
    check("final_busy", bus.busy, 0);
    check("pending_expectations", sb_q.size() + sk_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/systolic_skew_feeder.md
# systolic_skew_feeder

Upstream feeder for the N×N systolic matrix-multiply array of `pe` cells.
- Accepts one wavefront beat per handshake: column k of A and row k of B.
- Applies per-lane triangular skew (lane i delayed i cycles) and drives the array's west (`a`) and north (`b`) edges.
- Sequences each job: clears the PE accumulators, streams K beats, drains the array, then pulses `done` when every PE `out_c` holds its final dot product.

## Interface
- `DATA_W`, 8, operand width; matches PE `data_size`.
- `N`, 4, array dimension (rows = columns = lanes).
- `K`, 4, beats (inner dimension) per job; K ≥ 1.
- `clk`  in  1  single clock, rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `start`  in  1  begin job; sampled only in IDLE.
- `in_valid`  in  1  beat valid.
- `in_ready`  out  1  beat accepted when `in_valid & in_ready`.
- `in_a_vec`  in  N*DATA_W  A[i][k], lane i at bits [i*DATA_W +: DATA_W].
- `in_b_vec`  in  N*DATA_W  B[k][j], lane j likewise.
- `array_a`  out  N*DATA_W  lane i drives PE(i,0) `in_a`.
- `array_b`  out  N*DATA_W  lane j drives PE(0,j) `in_b`.
- `array_clr`  out  1  drives all PE `reset` (synchronous in PE).
- `busy`  out  1  high in any state except IDLE.
- `done`  out  1  one-cycle pulse; results valid.

## Operation
- States: IDLE → CLEAR → STREAM → DRAIN → DONE → IDLE.
- **IDLE**
  - `start`=1 → CLEAR.
  - `in_ready`=0; `in_valid` is ignored.
- **CLEAR**
  - Exactly 1 cycle; `array_clr`=1 → STREAM.
- **STREAM**
  - `in_ready`=1.
  - Beat counter (width $clog2(K+1)) increments per accepted beat.
  - When the K-th beat is accepted → DRAIN.
- **Bubbles**
  - A STREAM cycle with `in_valid`=0 shifts an all-zero wavefront into every lane of both edges.
  - Skew alignment is preserved, and a zero operand contributes 0 to the PE product.
- **DRAIN**
  - Exactly 2N-1 cycles; zeros shift in → DONE.
- **DONE**
  - 1 cycle, `done`=1 → IDLE.
- **Skew**
  - A lane i beat accepted at the end of cycle T appears on `array_a`/`array_b` lane i in cycle T+1+i.
  - Lane 0 is therefore one register deep and lane N-1 is N registers deep.
- Data passes unmodified; no offset-binary conversion happens here, because the PE consumes raw codes.
- `start` while `busy` is ignored; there is no queuing.
- `in_a_vec`/`in_b_vec` are don't-care when not accepted.

## Timing
- **Reset** (asynchronous, immediate):
  - state=IDLE, all delay registers 0, counters 0.
  - `array_a`=`array_b`=0; `array_clr`=`in_ready`=`busy`=`done`=0.
- **Reset mid-job:** the job is abandoned with no `done`. The next job's CLEAR re-zeros the PEs.
- `start` sampled in cycle S → CLEAR in cycle S+1 → first `in_ready` in cycle S+2.
- Last beat accepted in cycle L:
  - DRAIN covers cycles L+1 … L+2N-1; DONE is cycle L+2N.
  - PE(N-1,N-1) sees its last operands in L+2N-1, so all `out_c` are final at `done`.
- Minimum job length (no bubbles): 1 + 1 + K + (2N-1) + 1 cycles from `start` to `done`, inclusive.
- All outputs are registered. `in_ready` is a pure function of state, so there is no combinational path from `in_valid`.

## Structure
- `systolic_pkg`: `DATA_W`/`N` defaults and the `feeder_state_t` enum (IDLE, CLEAR, STREAM, DRAIN, DONE), shared with the later drain/collector block.
- Sub-module `skew_delay_line #(WIDTH, DEPTH)`:
  - DEPTH-stage register chain with async active-high reset.
  - Instantiated 2N times with DEPTH = i+1.
  - Shift-in data is the accepted lane value, else 0.
- The top level holds the FSM, beat counter, drain counter and output wiring.

## Test plan
- **Reset values:** assert `reset` mid-STREAM at K=4, N=4 → same cycle all outputs 0, state IDLE; a later `start` runs a clean job.
- **Identity multiply:** N=K=2, A=[[1,2],[3,4]], B=I, with the bench wiring 2×2 `pe` → `done` at `start`+1+1+2+3+1; `out_c`=[[1,2],[3,4]].
- **Skew check:** N=4, single beat with all lanes 0xFF → lane i nonzero only in cycle T+1+i; `array_b` matches.
- **Bubbles:** N=K=2 with `in_valid` low for 3 cycles between beats → identical `out_c`; `done` delayed by exactly 3 cycles.
- **Max operands:** N=K=4, all A=B=255 → every `out_c`=4·65025=260100; `done` 1+1+4+7+1 cycles after `start`.
- **Ignored inputs:** `start` pulsed during STREAM/DRAIN and `in_valid` in IDLE → no state change, no extra beat counted, single `done`.
